// File: rtl/wifi_tx_pilot_inserter.sv
// wifi_tx_pilot_inserter
// Buffers 48 mapped data symbols per OFDM symbol in two ping-pong banks.
// Each full bank is emitted as one 64-sample frame in IFFT natural order
// (n = k mod 64), with BPSK pilots, the DC null and the guard nulls inserted.
// Optional build macro: WIFI_TX_PILOT_POLARITY_EN
//   defined   -> pilot polarity follows the x^7+x^4+1 scrambler sequence
//   undefined -> pilot polarity is +1 on every frame (no LFSR is built)
module wifi_tx_pilot_inserter #(
  parameter int                      WIDTH     = 12,
  parameter logic signed [WIDTH-1:0] PILOT_AMP = 12'sd512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] data_in_real,
  input  logic signed [WIDTH-1:0] data_in_imag,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] data_out_real,
  output logic signed [WIDTH-1:0] data_out_imag,
  output logic                    sym_start,
  output logic                    sym_last,
  output logic                    overflow
);

  localparam int DEPTH = 48;
  localparam int SW    = 2 * WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  typedef enum logic [1:0] {
    SC_NULL,
    SC_DATA,
    SC_PILOT_POS,
    SC_PILOT_NEG
  } sc_kind_t;

  // Classify an output index: nulls, pilots (by base sign) or data.
  function automatic sc_kind_t sc_kind(input logic [5:0] n);
    sc_kind_t kind;
    kind = SC_DATA;
    if (n == 6'd0 || (n >= 6'd27 && n <= 6'd37)) begin
      kind = SC_NULL;
    end else if (n == 6'd7 || n == 6'd43 || n == 6'd57) begin
      kind = SC_PILOT_POS;
    end else if (n == 6'd21) begin
      kind = SC_PILOT_NEG;
    end
    return kind;
  endfunction

  // Buffer address holding the data symbol for output index n.
  // Positive subcarriers occupy addresses 24..47, negative ones 0..23.
  // Pilot and null positions return 0; their read data is never used.
  function automatic logic [5:0] sc_addr(input logic [5:0] n);
    logic [5:0] d;
    d = 6'd0;
    if (n >= 6'd1 && n <= 6'd6) begin
      d = n + 6'd23;
    end else if (n >= 6'd8 && n <= 6'd20) begin
      d = n + 6'd22;
    end else if (n >= 6'd22 && n <= 6'd26) begin
      d = n + 6'd21;
    end else if (n >= 6'd38 && n <= 6'd42) begin
      d = n - 6'd38;
    end else if (n >= 6'd44 && n <= 6'd56) begin
      d = n - 6'd39;
    end else if (n >= 6'd58) begin
      d = n - 6'd40;
    end
    return d;
  endfunction

  state_t          state_q;
  logic [5:0]      n_q;
  logic            rd_bank_q;
  logic            wr_bank_q;
  logic [5:0]      wr_cnt_q;
  logic [1:0]      full_q;
  logic [1:0]      full_d;
  logic [SW-1:0]   mem [0:2*DEPTH-1];
  logic [SW-1:0]   rd_data_q;

  logic            frame_end;
  logic            wr_target_free;
  logic            wr_accept;
  logic            wr_bank_done;
  logic [6:0]      wr_addr;
  logic [6:0]      rd_addr;
  logic [5:0]      rd_n_ahead;
  logic            pol_neg;
  logic signed [WIDTH-1:0] pilot_pos;
  logic signed [WIDTH-1:0] pilot_neg;

  // Last subcarrier of the frame being sent: the read bank is released here.
  assign frame_end = (state_q == ST_SEND) && (n_q == 6'd63);

  // A full bank still accepts a write if the reader releases it this cycle.
  assign wr_target_free = !full_q[wr_bank_q] || (frame_end && (rd_bank_q == wr_bank_q));
  assign wr_accept      = valid_in && wr_target_free;
  assign wr_bank_done   = wr_accept && (wr_cnt_q == 6'd47);

  assign wr_addr = (wr_bank_q ? 7'd48 : 7'd0) + {1'b0, wr_cnt_q};

  // The read is issued one subcarrier ahead so the registered RAM output
  // lines up with n_q in the output stage. Index 0 is always a null, so the
  // wrap from 63 to 0 never needs real data.
  assign rd_n_ahead = n_q + 6'd1;
  assign rd_addr    = (rd_bank_q ? 7'd48 : 7'd0) + {1'b0, sc_addr(rd_n_ahead)};

`ifdef WIFI_TX_PILOT_POLARITY_EN
  logic [6:0] lfsr_q;

  // Polarity bit for the current frame; also the bit shifted in on advance.
  assign pol_neg = lfsr_q[6] ^ lfsr_q[3];

  // Pilot scrambler: one step per completed frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 7'b1111111;
    end else if (frame_end) begin
      lfsr_q <= {lfsr_q[5:0], pol_neg};
    end
  end
`else
  assign pol_neg = 1'b0;
`endif

  assign pilot_pos = pol_neg ? -PILOT_AMP : PILOT_AMP;
  assign pilot_neg = pol_neg ? PILOT_AMP : -PILOT_AMP;

  // Per-bank full flag next state: completion sets, release at frame end clears.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign full_d[gi] = (wr_bank_done && (wr_bank_q == 1'(gi))) |
                        (full_q[gi] & ~(frame_end && (rd_bank_q == 1'(gi))));
  end

  // Bank full flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

  // Sample store: mapper write port and one-ahead registered read port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr] <= {data_in_real, data_in_imag};
    end
    rd_data_q <= mem[rd_addr];
  end

  // Write pointer and sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q  <= 6'd0;
      wr_bank_q <= 1'b0;
      overflow  <= 1'b0;
    end else if (valid_in) begin
      if (wr_accept) begin
        if (wr_cnt_q == 6'd47) begin
          wr_cnt_q  <= 6'd0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + 6'd1;
        end
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  // Read sequencer: wait for a full bank, then walk n = 0..63 without gaps,
  // chaining straight into the other bank when it is (or becomes) full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      n_q       <= 6'd0;
      rd_bank_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          n_q <= 6'd0;
          if (full_q[rd_bank_q]) begin
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          n_q <= n_q + 6'd1;
          if (n_q == 6'd63) begin
            rd_bank_q <= ~rd_bank_q;
            if (!full_d[~rd_bank_q]) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          n_q     <= 6'd0;
        end
      endcase
    end
  end

  // Output stage: select data, pilot or null for the current index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out     <= 1'b0;
      sym_start     <= 1'b0;
      sym_last      <= 1'b0;
      data_out_real <= '0;
      data_out_imag <= '0;
    end else begin
      valid_out     <= (state_q == ST_SEND);
      sym_start     <= (state_q == ST_SEND) && (n_q == 6'd0);
      sym_last      <= frame_end;
      data_out_real <= '0;
      data_out_imag <= '0;
      if (state_q == ST_SEND) begin
        case (sc_kind(n_q))
          SC_DATA: begin
            data_out_real <= rd_data_q[SW-1:WIDTH];
            data_out_imag <= rd_data_q[WIDTH-1:0];
          end
          SC_PILOT_POS: data_out_real <= pilot_pos;
          SC_PILOT_NEG: data_out_real <= pilot_neg;
          default: begin
          end
        endcase
      end
    end
  end

endmodule
